// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream reset; retries on lock timeout and latches FAIL after repeated timeouts.
module pll_reset_sequencer #(
    parameter int POR_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int MAX_A = (POR_CYCLES > LOCK_STABLE) ? POR_CYCLES : LOCK_STABLE;
    localparam int MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] POR_LAST    = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          locked_s;
    logic [3:0]    retry_inc_s;

    assign locked_s    = sync2_q;
    assign retry_inc_s = retry_q + 4'd1;

    // Next-state, counter and output decode; outputs derive from state_d so they
    // register on the same edge as the state itself.
    always_comb begin
        sync1_d  = pll_locked;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        loss_d   = loss_q;

        if (force_relock) begin
            state_d = ST_RESET_PLL;
            cnt_d   = CNT_ZERO;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == POR_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        retry_d = retry_inc_s;
                        if (retry_inc_s == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_PLL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                        retry_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = CNT_ZERO;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= CNT_ZERO;
            retry_q   <= 4'd0;
            loss_q    <= 8'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse (>=1).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-locked cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 50000: maximum WAIT_LOCK cycles per attempt (>=1).
REQ-004 SHALL have parameter MAX_RETRY, default 3: consecutive lock timeouts that cause FAIL (1..15).
REQ-005 refclk  input  1  single clock (50 MHz PLL reference); all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL locked, asynchronous to refclk.
REQ-008 force_relock  input  1  single-cycle request to restart the PLL sequence.
REQ-009 pll_rst  output  1  PLL reset, active-high.
REQ-010 sys_rst  output  1  downstream reset for the outclk domains, active-high.
REQ-011 ready  output  1  high only while the PLL is locked and released.
REQ-012 fail  output  1  high in FAIL state.
REQ-013 retry_cnt  output  4  consecutive timeouts in the current attempt sequence.
REQ-014 loss_cnt  output  8  lock-loss events while in RUN, saturating at 255.
REQ-015 state  output  3  current state encoding.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer (locked_s), giving 2 cycles of latency; no other logic SHALL use pll_locked directly.
REQ-017 States/encodings SHALL be: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; other codes SHALL go to RESET_PLL on the next cycle.
REQ-018 RESET_PLL SHALL last exactly POR_CYCLES cycles, then go to WAIT_LOCK with the cycle counter cleared.
REQ-019 WAIT_LOCK: locked_s=1 SHALL go to STABLE. If LOCK_TIMEOUT cycles elapse without lock, retry_cnt SHALL increment. If the new value equals MAX_RETRY, the next state SHALL be FAIL; otherwise RESET_PLL.
REQ-020 STABLE SHALL count consecutive locked_s=1 cycles and go to RUN after LOCK_STABLE cycles. Any locked_s=0 SHALL return to WAIT_LOCK with counters cleared and no retry increment.
REQ-021 Entering RUN SHALL clear retry_cnt.
REQ-022 In RUN, locked_s=0 SHALL go to RESET_PLL and increment loss_cnt (saturating).
REQ-023 FAIL SHALL persist until rst or force_relock.
REQ-024 force_relock=1 in any state SHALL go to RESET_PLL, clear retry_cnt and counters, and keep loss_cnt.
REQ-025 Priority SHALL be rst > force_relock > state transitions.
REQ-026 All outputs SHALL be registered and SHALL change on the same edge as the state register.
REQ-027 pll_rst SHALL be 1 in RESET_PLL and FAIL, and 0 otherwise.
REQ-028 sys_rst SHALL be 1 in every state except RUN.
REQ-029 ready SHALL be 1 only in RUN.
REQ-030 fail SHALL be 1 only in FAIL.
REQ-031 There SHALL be no combinational path from any input to any output.
REQ-032 Counters SHALL be sized to hold max(POR_CYCLES, LOCK_STABLE, LOCK_TIMEOUT) without wrap.

Reset
REQ-033 On rst=1 at a clock edge: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, counters=0, synchronizer flops=0.
REQ-034 After rst deasserts, RESET_PLL SHALL last a full POR_CYCLES cycles; rst mid-operation SHALL abort the current state immediately with no partial release.

Verification (POR_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=20, MAX_RETRY=2)
REQ-035 Nominal: rst released, pll_locked=1 from cycle 6 -> pll_rst high for cycles 0-3, state=2 after synchronizer delay, ready=1 and sys_rst=0 after 8 stable cycles, retry_cnt=0.
REQ-036 Glitch: pll_locked drops for 1 cycle during STABLE -> state returns to 1, stable count restarts, ready stays 0, retry_cnt unchanged.
REQ-037 Timeout to FAIL: pll_locked held 0 -> two 20-cycle WAIT_LOCK windows, retry_cnt 1 then 2, state=4, fail=1, pll_rst=1, sys_rst=1.
REQ-038 Lock loss: in RUN, pll_locked=0 -> 2 cycles later state=0, sys_rst=1, ready=0, loss_cnt=1; relock with pll_locked=1 -> RUN again, loss_cnt stays 1.
REQ-039 force_relock in FAIL and in RUN -> next cycle state=0, retry_cnt=0, pll_rst=1, loss_cnt preserved.
REQ-040 rst and force_relock asserted together mid-STABLE -> full reset values, including loss_cnt=0.
